// File: rtl/rf_pkg.sv
// Shared types and helpers for the scoreboarded register file.
// Holds default sizes and the address validity rule used by all ports.
package rf_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 32;

    typedef logic [$clog2(DEF_DEPTH)-1:0] reg_addr_t;

    // An address is usable if it is in range and not the hardwired zero.
    function automatic logic addr_valid(
        input int unsigned addr,
        input int unsigned depth,
        input logic        zero_reg
    );
        return (addr < depth) && !(zero_reg && (addr == 0));
    endfunction

endpackage

// File: rtl/rf_busy_sb.sv
// Per-register busy scoreboard for decode-stage RAW hazard detection.
// Tracks outstanding producers and keeps a running busy count.
module rf_busy_sb
    import rf_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    output logic              rd_busy_1,
    output logic              rd_busy_2,
    output logic [ADDR_W:0]   busy_count
);

    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;
    logic             set_ok;
    logic             clr_ok;
    logic             same;
    logic             inc;
    logic             dec;
    logic             rd1_ok;
    logic             rd2_ok;

    assign set_ok = issue_en && addr_valid(32'(issue_addr), DEPTH, ZERO_REG != 0);
    assign clr_ok = wr_en && addr_valid(32'(wr_addr), DEPTH, ZERO_REG != 0);
    assign same   = issue_addr == wr_addr;
    assign rd1_ok = addr_valid(32'(rd_addr_1), DEPTH, ZERO_REG != 0);
    assign rd2_ok = addr_valid(32'(rd_addr_2), DEPTH, ZERO_REG != 0);

    // Next busy vector: retire first, then a new producer overrides it.
    always_comb begin
        busy_next = busy;
        inc       = 1'b0;
        dec       = 1'b0;
        if (clr_ok) begin
            busy_next[wr_addr] = 1'b0;
            dec = busy[wr_addr] && !(set_ok && same);
        end
        if (set_ok) begin
            busy_next[issue_addr] = 1'b1;
            inc = !busy[issue_addr];
        end
    end

    // Busy bits and incremental popcount.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy <= busy_next;
            if (inc && !dec)
                busy_count <= busy_count + CNT_ONE;
            else if (dec && !inc)
                busy_count <= busy_count - CNT_ONE;
        end
    end

    // A producer retiring this cycle is bypassed, so it is no hazard.
    always_comb begin
        rd_busy_1 = rd1_ok && busy[rd_addr_1]
                 && !(wr_en && wr_addr == rd_addr_1);
        rd_busy_2 = rd2_ok && busy[rd_addr_2]
                 && !(wr_en && wr_addr == rd_addr_2);
    end

endmodule

// File: rtl/rf_scoreboard.sv
// 2-read/1-write register file with write bypass and busy scoreboard.
// Storage and read muxes live here; hazard tracking is in rf_busy_sb.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    output logic [DATA_W-1:0] rd_data_1,
    output logic [DATA_W-1:0] rd_data_2,
    output logic              rd_busy_1,
    output logic              rd_busy_2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic [ADDR_W:0]   busy_count
);

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_ok;
    logic              rd1_ok;
    logic              rd2_ok;

    assign wr_ok  = wr_en && addr_valid(32'(wr_addr), DEPTH, ZERO_REG != 0);
    assign rd1_ok = rst_n && addr_valid(32'(rd_addr_1), DEPTH, ZERO_REG != 0);
    assign rd2_ok = rst_n && addr_valid(32'(rd_addr_2), DEPTH, ZERO_REG != 0);

    // Register storage, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read muxes with same-cycle write bypass.
    always_comb begin
        rd_data_1 = '0;
        rd_data_2 = '0;
        if (rd1_ok)
            rd_data_1 = (wr_en && wr_addr == rd_addr_1) ? wr_data : regs[rd_addr_1];
        if (rd2_ok)
            rd_data_2 = (wr_en && wr_addr == rd_addr_2) ? wr_data : regs[rd_addr_2];
    end

    rf_busy_sb #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .rd_addr_1  (rd_addr_1),
        .rd_addr_2  (rd_addr_2),
        .rd_busy_1  (rd_busy_1),
        .rd_busy_2  (rd_busy_2),
        .busy_count (busy_count)
    );

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard: directed cases plus random
// traffic against a behavioural model, and a DEPTH=24 no-zero-reg instance.
module tb_rf_scoreboard;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_addr_t   rd_addr_1, rd_addr_2, wr_addr, issue_addr;
    logic [31:0] rd_data_1, rd_data_2, wr_data;
    logic        rd_busy_1, rd_busy_2, wr_en, issue_en;
    logic [5:0]  busy_count;

    logic [4:0]  r_rd_addr_1, r_rd_addr_2, r_wr_addr, r_issue_addr;
    logic [31:0] r_rd_data_1, r_rd_data_2, r_wr_data;
    logic        r_rd_busy_1, r_rd_busy_2, r_wr_en, r_issue_en;
    logic [5:0]  r_busy_count;

    rf_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
        .rd_busy_1(rd_busy_1), .rd_busy_2(rd_busy_2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .busy_count(busy_count)
    );

    rf_scoreboard #(.DEPTH(24), .ZERO_REG(0)) dut_r (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_1(r_rd_addr_1), .rd_addr_2(r_rd_addr_2),
        .rd_data_1(r_rd_data_1), .rd_data_2(r_rd_data_2),
        .rd_busy_1(r_rd_busy_1), .rd_busy_2(r_rd_busy_2),
        .wr_en(r_wr_en), .wr_addr(r_wr_addr), .wr_data(r_wr_data),
        .issue_en(r_issue_en), .issue_addr(r_issue_addr),
        .busy_count(r_busy_count)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [32];
    bit          m_busy [32];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wr_en && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic logic m_hazard(input logic [4:0] a);
        return (a != 0) && m_busy[a] && !(wr_en && wr_addr == a);
    endfunction

    function automatic logic [5:0] m_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        return 6'(n);
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'h0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ie, input logic [4:0] ia,
                         input logic [4:0] r1, input logic [4:0] r2);
        wr_en = we; wr_addr = wa; wr_data = wd;
        issue_en = ie; issue_addr = ia;
        rd_addr_1 = r1; rd_addr_2 = r2;
    endtask

    // Check combinational outputs mid-cycle, then clock and update the model.
    task automatic cycle(input string tag);
        #3;
        check({tag, "_rd1"}, 64'(rd_data_1), 64'(m_read(rd_addr_1)));
        check({tag, "_rd2"}, 64'(rd_data_2), 64'(m_read(rd_addr_2)));
        check({tag, "_busy1"}, 64'(rd_busy_1), 64'(m_hazard(rd_addr_1)));
        check({tag, "_busy2"}, 64'(rd_busy_2), 64'(m_hazard(rd_addr_2)));
        check({tag, "_count"}, 64'(busy_count), 64'(m_count()));
        @(posedge clk);
        if (wr_en && wr_addr != 0) begin
            m_regs[wr_addr] = wr_data;
            m_busy[wr_addr] = 1'b0;
        end
        if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
        #1;
    endtask

    initial begin
        logic [5:0] cnt_before;
        m_clear();
        r_wr_en = 0; r_wr_addr = 0; r_wr_data = 0;
        r_issue_en = 0; r_issue_addr = 0;
        r_rd_addr_1 = 0; r_rd_addr_2 = 0;

        // Reads in reset are 0 even with a bypassing write present.
        drive(1, 5, 32'hCAFE_F00D, 1, 5, 5, 5);
        #3;
        check("rst_rd1", 64'(rd_data_1), 64'h0);
        check("rst_busy1", 64'(rd_busy_1), 64'h0);
        check("rst_count", 64'(busy_count), 64'h0);
        check("rst_r_count", 64'(r_busy_count), 64'h0);
        @(posedge clk); #1;
        check("rst_held_count", 64'(busy_count), 64'h0);
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Write r5 and mark it busy, then reset mid-cycle.
        drive(1, 5, 32'hDEAD_BEEF, 0, 0, 5, 0);
        cycle("wr5");
        drive(0, 0, 0, 1, 5, 5, 5);
        cycle("iss5");
        drive(0, 0, 0, 0, 0, 5, 5);
        #1;
        check("pre_rst_r5", 64'(rd_data_1), 64'hDEAD_BEEF);
        check("pre_rst_cnt", 64'(busy_count), 64'h1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_r5", 64'(rd_data_1), 64'h0);
        check("async_rst_busy", 64'(rd_busy_1), 64'h0);
        check("async_rst_cnt", 64'(busy_count), 64'h0);
        m_clear();
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Bypass on r7.
        drive(1, 7, 32'h1234_5678, 0, 0, 7, 6);
        #3;
        check("bypass_rd1", 64'(rd_data_1), 64'h1234_5678);
        #0;
        rd_addr_1 = 7;
        cycle("bypass");
        drive(0, 0, 0, 0, 0, 7, 7);
        #1;
        check("stored_r7", 64'(rd_data_1), 64'h1234_5678);
        cycle("stored7");

        // Zero register ignores writes and issues.
        drive(1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0);
        cycle("zero_w");
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("zero_rd", 64'(rd_data_1), 64'h0);
        check("zero_busy", 64'(rd_busy_2), 64'h0);
        check("zero_cnt", 64'(busy_count), 64'h0);
        cycle("zero_r");

        // Issue r3, retire it next cycle.
        drive(0, 0, 0, 1, 3, 3, 3);
        cycle("sb_iss3");
        drive(0, 0, 0, 0, 0, 3, 3);
        #1;
        check("sb_busy3", 64'(rd_busy_1), 64'h1);
        check("sb_cnt1", 64'(busy_count), 64'h1);
        wr_en = 1; wr_addr = 3; wr_data = 32'h33;
        #1;
        check("sb_retire_busy", 64'(rd_busy_1), 64'h0);
        cycle("sb_wr3");
        drive(0, 0, 0, 0, 0, 3, 0);
        #1;
        check("sb_cnt0", 64'(busy_count), 64'h0);
        cycle("sb_after");

        // Collision on busy r9.
        drive(0, 0, 0, 1, 9, 9, 0);
        cycle("col_iss");
        cnt_before = busy_count;
        drive(1, 9, 32'hA5A5_5A5A, 1, 9, 9, 0);
        cycle("col_both");
        drive(0, 0, 0, 0, 0, 9, 9);
        #1;
        check("col_busy", 64'(rd_busy_1), 64'h1);
        check("col_cnt", 64'(busy_count), 64'(cnt_before));
        check("col_data", 64'(rd_data_2), 64'hA5A5_5A5A);
        cycle("col_after");

        // Different-address issue and retire in one cycle.
        drive(1, 9, 32'h99, 1, 11, 9, 11);
        cycle("diff");
        drive(0, 0, 0, 0, 0, 9, 11);
        cycle("diff_after");

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            logic [4:0] wa;
            wa = 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), wa, $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)));
            cycle("rand");
        end
        drive(0, 0, 0, 0, 0, 0, 0);

        // DEPTH=24, no zero register.
        r_wr_en = 1; r_wr_addr = 30; r_wr_data = 32'hDEAD;
        r_rd_addr_1 = 30;
        #3;
        check("r_bypass_oob", 64'(r_rd_data_1), 64'h0);
        @(posedge clk); #1;
        r_wr_addr = 0; r_wr_data = 32'h55;
        r_issue_en = 1; r_issue_addr = 30;
        r_rd_addr_1 = 0;
        #3;
        check("r_bypass_r0", 64'(r_rd_data_1), 64'h55);
        @(posedge clk); #1;
        r_wr_addr = 23; r_wr_data = 32'h77;
        r_issue_en = 1; r_issue_addr = 0;
        r_rd_addr_1 = 0; r_rd_addr_2 = 30;
        #3;
        check("r_r0_data", 64'(r_rd_data_1), 64'h55);
        check("r_oob_rd", 64'(r_rd_data_2), 64'h0);
        check("r_oob_busy", 64'(r_rd_busy_2), 64'h0);
        check("r_oob_cnt", 64'(r_busy_count), 64'h0);
        @(posedge clk); #1;
        r_wr_en = 0; r_issue_en = 0;
        r_rd_addr_1 = 0; r_rd_addr_2 = 23;
        #1;
        check("r_r0_busy", 64'(r_rd_busy_1), 64'h1);
        check("r_r0_cnt", 64'(r_busy_count), 64'h1);
        check("r_r23", 64'(r_rd_data_2), 64'h77);
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
